// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: branch condition codes and FSM state encodings.
// Imported by the interface, the condition evaluator and the top level.
// Condition codes are 8-bit values; wider datapaths compare against them zero-extended.
package pc_sequencer_pkg;

  localparam logic [7:0] BR_SMALLER  = 8'h01;  // op0 <  op1
  localparam logic [7:0] BR_EQUAL    = 8'h02;  // op0 == op1
  localparam logic [7:0] BR_LARGER   = 8'h03;  // op0 >  op1
  localparam logic [7:0] BR_NSMALLER = 8'h04;  // !(op0 < op1)
  localparam logic [7:0] BR_NEQUAL   = 8'h05;  // op0 != op1
  localparam logic [7:0] BR_NLARGER  = 8'h06;  // !(op0 > op1)

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_BRANCH = 3'd3,
    SEQ_HALT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake and execute-completion bus between the sequencer and the memory/execute side.
// Ports: o_fetch_req/o_fetch_addr out of the sequencer, i_fetch_ack back; i_exec_valid with its
// qualifiers (i_is_branch, i_halt, i_br_cond, i_br_target, i_operand0, i_operand1) into the sequencer.
interface pc_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  o_fetch_req;
  logic [DATA_WIDTH-1:0] o_fetch_addr;
  logic                  i_fetch_ack;
  logic                  i_exec_valid;
  logic                  i_is_branch;
  logic                  i_halt;
  logic [DATA_WIDTH-1:0] i_br_cond;
  logic [DATA_WIDTH-1:0] i_br_target;
  logic [DATA_WIDTH-1:0] i_operand0;
  logic [DATA_WIDTH-1:0] i_operand1;

  // Sequencer side
  modport master (
    output o_fetch_req, o_fetch_addr,
    input  i_fetch_ack, i_exec_valid, i_is_branch, i_halt,
    input  i_br_cond, i_br_target, i_operand0, i_operand1
  );

  // Memory / execute side
  modport slave (
    input  o_fetch_req, o_fetch_addr,
    output i_fetch_ack, i_exec_valid, i_is_branch, i_halt,
    output i_br_cond, i_br_target, i_operand0, i_operand1
  );
endinterface

// File: rtl/pc_sequencer_branch_cond_eval.sv
// Combinational branch condition evaluator; unsigned compare of op0 against op1.
// Ports: cond (condition code), op0, op1 in; taken out. Unknown codes are never taken.
// No state, zero latency.
module branch_cond_eval
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] cond,
  input  logic [DATA_WIDTH-1:0] op0,
  input  logic [DATA_WIDTH-1:0] op1,
  output logic                  taken
);

  logic lt, eq, gt;

  always_comb begin
    lt    = (op0 < op1);
    eq    = (op0 == op1);
    gt    = (op0 > op1);
    taken = 1'b0;
    case (cond)
      DATA_WIDTH'(BR_SMALLER):  taken = lt;
      DATA_WIDTH'(BR_EQUAL):    taken = eq;
      DATA_WIDTH'(BR_LARGER):   taken = gt;
      DATA_WIDTH'(BR_NSMALLER): taken = !lt;
      DATA_WIDTH'(BR_NEQUAL):   taken = !eq;
      DATA_WIDTH'(BR_NLARGER):  taken = !gt;
      default:                  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE -> FETCH (req/ack) -> EXEC -> FETCH / BRANCH / HALT.
// Ports: clk, rst, i_start, i_boot_addr, bus (fetch handshake + execute results), o_pc,
// o_branch_taken/o_flush pulses, o_busy, o_halted; o_taken_cnt only when PC_SEQ_PERF_EN is defined.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PC_STEP    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_boot_addr,
  pc_sequencer_if.master        bus,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_branch_taken,
  output logic                  o_flush,
  output logic                  o_busy,
  output logic                  o_halted
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0]           o_taken_cnt
`endif
);

  seq_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0] br_cond_q, br_target_q, op0_q, op1_q;
  logic                  ld_br;
  logic                  br_taken;
  logic                  start_acc;

  // Evaluated on the operands captured at EXEC completion, so the compare
  // gets a full cycle of its own in BRANCH.
  branch_cond_eval #(.DATA_WIDTH(DATA_WIDTH)) u_cond (
    .cond  (br_cond_q),
    .op0   (op0_q),
    .op1   (op1_q),
    .taken (br_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEQ_IDLE;
      pc          <= '0;
      br_cond_q   <= '0;
      br_target_q <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ld_br) begin
        br_cond_q   <= bus.i_br_cond;
        br_target_q <= bus.i_br_target;
        op0_q       <= bus.i_operand0;
        op1_q       <= bus.i_operand1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    ld_br          = 1'b0;
    start_acc      = 1'b0;
    o_pc           = pc;
    o_branch_taken = 1'b0;
    o_flush        = 1'b0;
    o_busy         = 1'b0;
    o_halted       = 1'b0;
    case (state)
      SEQ_IDLE, SEQ_HALT: begin
        o_halted = (state == SEQ_HALT);
        if (i_start) begin
          start_acc = 1'b1;
          state_nxt = SEQ_FETCH;
          pc_nxt    = i_boot_addr;
        end
      end
      SEQ_FETCH: begin
        o_busy = 1'b1;
        if (bus.i_fetch_ack) state_nxt = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        o_busy = 1'b1;
        if (bus.i_exec_valid) begin
          // HALT wins over a simultaneous branch flag; PC holds.
          if (bus.i_halt) begin
            state_nxt = SEQ_HALT;
          end else if (bus.i_is_branch) begin
            state_nxt = SEQ_BRANCH;
            ld_br     = 1'b1;
          end else begin
            state_nxt = SEQ_FETCH;
            pc_nxt    = pc + DATA_WIDTH'(PC_STEP);
          end
        end
      end
      SEQ_BRANCH: begin
        o_busy         = 1'b1;
        state_nxt      = SEQ_FETCH;
        o_branch_taken = br_taken;
        o_flush        = br_taken;
        pc_nxt         = br_taken ? br_target_q : pc + DATA_WIDTH'(PC_STEP);
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  // Request is a pure decode of the state register, so reset drops it asynchronously.
  assign bus.o_fetch_req  = (state == SEQ_FETCH);
  assign bus.o_fetch_addr = pc;

`ifdef PC_SEQ_PERF_EN
  logic [15:0] taken_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (start_acc) begin
      taken_cnt <= '0;
    end else if (o_branch_taken && (taken_cnt != 16'hFFFF)) begin
      taken_cnt <= taken_cnt + 16'd1;
    end
  end

  assign o_taken_cnt = taken_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot fetch, sequential step, branch condition table,
// PC wrap, halt/restart, async reset mid-fetch; taken counter when PC_SEQ_PERF_EN is defined.
// Inputs are driven and outputs sampled just after the falling edge.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_boot_addr;
  logic [7:0] o_pc;
  logic       o_branch_taken, o_flush, o_busy, o_halted;
`ifdef PC_SEQ_PERF_EN
  logic [15:0] o_taken_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_pc;

  pc_sequencer_if #(.DATA_WIDTH(8)) bus ();

  pc_sequencer #(.DATA_WIDTH(8), .PC_STEP(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_boot_addr    (i_boot_addr),
    .bus            (bus),
    .o_pc           (o_pc),
    .o_branch_taken (o_branch_taken),
    .o_flush        (o_flush),
    .o_busy         (o_busy),
    .o_halted       (o_halted)
`ifdef PC_SEQ_PERF_EN
    ,
    .o_taken_cnt    (o_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] cond;
    logic [7:0] op0;
    logic [7:0] op1;
    logic [7:0] tgt;
    logic       tk;
    logic [7:0] nxt;
  } bvec_t;

  bvec_t vecs[10];

  // In FETCH with addr expected: check it, acknowledge, land in EXEC.
  task automatic fetch_ack(input logic [7:0] addr);
    check("fetch_req", 32'(bus.o_fetch_req), 32'd1);
    check("fetch_addr", 32'(bus.o_fetch_addr), 32'(addr));
    bus.i_fetch_ack = 1'b1;
    @(negedge clk);
    bus.i_fetch_ack = 1'b0;
    check("req_drop", 32'(bus.o_fetch_req), 32'd0);
  endtask

  task automatic run_branch(input int idx, input bvec_t v);
    fetch_ack(exp_pc);
    bus.i_exec_valid = 1'b1;
    bus.i_is_branch  = 1'b1;
    bus.i_br_cond    = v.cond;
    bus.i_operand0   = v.op0;
    bus.i_operand1   = v.op1;
    bus.i_br_target  = v.tgt;
    @(negedge clk);
    bus.i_exec_valid = 1'b0;
    bus.i_is_branch  = 1'b0;
    bus.i_br_cond    = 8'h00;
    check($sformatf("br%0d_taken", idx), 32'(o_branch_taken), 32'(v.tk));
    check($sformatf("br%0d_flush", idx), 32'(o_flush), 32'(v.tk));
    check($sformatf("br%0d_noreq", idx), 32'(bus.o_fetch_req), 32'd0);
    @(negedge clk);
    check($sformatf("br%0d_pulse_end", idx), 32'({o_branch_taken, o_flush}), 32'd0);
    check($sformatf("br%0d_next", idx), 32'(bus.o_fetch_addr), 32'(v.nxt));
    exp_pc = v.nxt;
  endtask

  task automatic run_step();
    fetch_ack(exp_pc);
    bus.i_exec_valid = 1'b1;
    @(negedge clk);
    bus.i_exec_valid = 1'b0;
    exp_pc = exp_pc + 8'd1;
    check("step_req", 32'(bus.o_fetch_req), 32'd1);
    check("step_addr", 32'(bus.o_fetch_addr), 32'(exp_pc));
    check("step_noflush", 32'(o_flush), 32'd0);
  endtask

  initial begin
    //             cond   op0    op1    tgt    tk    next
    vecs[0] = '{8'h01, 8'd3, 8'd5, 8'h40, 1'b1, 8'h40};
    vecs[1] = '{8'h01, 8'd5, 8'd5, 8'h70, 1'b0, 8'h41};
    vecs[2] = '{8'h07, 8'd3, 8'd5, 8'h70, 1'b0, 8'h42};
    vecs[3] = '{8'h00, 8'd5, 8'd5, 8'h70, 1'b0, 8'h43};
    vecs[4] = '{8'h02, 8'd9, 8'd9, 8'h60, 1'b1, 8'h60};
    vecs[5] = '{8'h03, 8'd7, 8'd2, 8'h80, 1'b1, 8'h80};
    vecs[6] = '{8'h04, 8'd2, 8'd7, 8'h90, 1'b0, 8'h81};
    vecs[7] = '{8'h05, 8'd2, 8'd2, 8'h90, 1'b0, 8'h82};
    vecs[8] = '{8'h06, 8'd7, 8'd2, 8'h90, 1'b0, 8'h83};
    vecs[9] = '{8'h06, 8'd2, 8'd2, 8'hFF, 1'b1, 8'hFF};

    rst = 1'b1;
    i_start = 1'b0;
    i_boot_addr = 8'h00;
    bus.i_fetch_ack  = 1'b0;
    bus.i_exec_valid = 1'b0;
    bus.i_is_branch  = 1'b0;
    bus.i_halt       = 1'b0;
    bus.i_br_cond    = 8'h00;
    bus.i_br_target  = 8'h00;
    bus.i_operand0   = 8'h00;
    bus.i_operand1   = 8'h00;
    repeat (2) @(negedge clk);

    check("rst_pc", 32'(o_pc), 32'h0);
    check("rst_req", 32'(bus.o_fetch_req), 32'd0);
    check("rst_flags", 32'({o_branch_taken, o_flush, o_busy, o_halted}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Boot at 0x10, acknowledge on the third request cycle.
    i_start = 1'b1;
    i_boot_addr = 8'h10;
    @(negedge clk);
    i_start = 1'b0;
    check("boot_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < 2; k++) begin
      check("boot_hold_req", 32'(bus.o_fetch_req), 32'd1);
      check("boot_hold_addr", 32'(bus.o_fetch_addr), 32'h10);
      @(negedge clk);
    end
    exp_pc = 8'h10;
    run_step();
    check("exec_busy_prev", 32'(o_busy), 32'd1);

    for (int i = 0; i < 10; i++) run_branch(i, vecs[i]);

    // 0xFF + 1 wraps to 0x00.
    run_step();

    // In EXEC: start is ignored, then halt with branch flag set.
    fetch_ack(exp_pc);
    i_start = 1'b1;
    i_boot_addr = 8'h55;
    @(negedge clk);
    i_start = 1'b0;
    check("start_ign_pc", 32'(o_pc), 32'h00);
    check("start_ign_busy", 32'(o_busy), 32'd1);
    check("start_ign_req", 32'(bus.o_fetch_req), 32'd0);
    bus.i_exec_valid = 1'b1;
    bus.i_is_branch  = 1'b1;
    bus.i_halt       = 1'b1;
    bus.i_br_cond    = 8'h02;
    @(negedge clk);
    bus.i_exec_valid = 1'b0;
    bus.i_is_branch  = 1'b0;
    bus.i_halt       = 1'b0;
    check("halt_halted", 32'(o_halted), 32'd1);
    check("halt_busy", 32'(o_busy), 32'd0);
    check("halt_pc", 32'(o_pc), 32'h00);
    check("halt_nopulse", 32'({o_branch_taken, o_flush}), 32'd0);
`ifdef PC_SEQ_PERF_EN
    check("taken_cnt", 32'(o_taken_cnt), 32'd4);
`endif
    i_start = 1'b1;
    i_boot_addr = 8'h20;
    @(negedge clk);
    i_start = 1'b0;
    check("restart_req", 32'(bus.o_fetch_req), 32'd1);
    check("restart_addr", 32'(bus.o_fetch_addr), 32'h20);
    check("restart_halted", 32'(o_halted), 32'd0);
`ifdef PC_SEQ_PERF_EN
    check("taken_cnt_clr", 32'(o_taken_cnt), 32'd0);
`endif

    // Async reset mid-cycle while the request is pending.
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(bus.o_fetch_req), 32'd0);
    check("arst_pc", 32'(o_pc), 32'h00);
    check("arst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'({bus.o_fetch_req, o_busy, o_halted}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
